// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-boxes, round constants, GF(2^8) helpers,
// the iterative FSM state type and block-size constants.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Round constant for key-schedule step 1..10; index 0 and 11..15 unused.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        case (idx)
            4'd1:  r = 8'h01; 4'd2:  r = 8'h02; 4'd3:  r = 8'h04; 4'd4: r = 8'h08; 4'd5: r = 8'h10;
            4'd6:  r = 8'h20; 4'd7:  r = 8'h40; 4'd8:  r = 8'h80; 4'd9: r = 8'h1b; 4'd10: r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // SubWord(RotWord(w)) as used by both key-schedule directions.
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

endpackage

// File: rtl/aes_inv_round_128.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and, unless
// skip_mix is set for the last round, InvMixColumns. Purely combinational.
module aes_inv_round_128
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               skip_mix,
    output logic [BLOCK_W-1:0] state_out
);

    logic [7:0] w_ark [16];
    logic [7:0] w_mix [16];

    // Byte r+4c is row r of column c; row r is rotated right by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[4*c+r] = inv_sbox(state_in[127 - 8*(4*((c - r + 4) % 4) + r) -: 8])
                             ^ round_key[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    // InvMixColumns with the row-rotated 0e 0b 0d 09 matrix.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_mix[4*c+0] = gf_mul(w_ark[4*c+0], 8'h0e) ^ gf_mul(w_ark[4*c+1], 8'h0b)
                         ^ gf_mul(w_ark[4*c+2], 8'h0d) ^ gf_mul(w_ark[4*c+3], 8'h09);
            w_mix[4*c+1] = gf_mul(w_ark[4*c+0], 8'h09) ^ gf_mul(w_ark[4*c+1], 8'h0e)
                         ^ gf_mul(w_ark[4*c+2], 8'h0b) ^ gf_mul(w_ark[4*c+3], 8'h0d);
            w_mix[4*c+2] = gf_mul(w_ark[4*c+0], 8'h0d) ^ gf_mul(w_ark[4*c+1], 8'h09)
                         ^ gf_mul(w_ark[4*c+2], 8'h0e) ^ gf_mul(w_ark[4*c+3], 8'h0b);
            w_mix[4*c+3] = gf_mul(w_ark[4*c+0], 8'h0b) ^ gf_mul(w_ark[4*c+1], 8'h0d)
                         ^ gf_mul(w_ark[4*c+2], 8'h09) ^ gf_mul(w_ark[4*c+3], 8'h0e);
        end
    end

    // Repack bytes, bypassing the mix stage in the final round.
    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8*i -: 8] = skip_mix ? w_ark[i] : w_mix[i];
        end
    end

endmodule

// File: rtl/decryption_128_iter.sv
// Iterative AES-128 decryptor: ten forward key-schedule steps to reach the
// last round key, then ten inverse rounds that walk the schedule backwards.
module decryption_128_iter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] cipher_text,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] plain_text,
    output logic               busy
);

    fsm_state_t         r_fsm;
    logic [BLOCK_W-1:0] r_key;
    logic [BLOCK_W-1:0] r_state;
    logic [3:0]         r_rcnt;

    logic [31:0]        w_w0, w_w1, w_w2, w_w3;
    logic [31:0]        w_f0, w_f1, w_f2, w_f3;
    logic [31:0]        w_p0, w_p1, w_p2, w_p3;
    logic [BLOCK_W-1:0] w_key_fwd;
    logic [BLOCK_W-1:0] w_key_bwd;
    logic [BLOCK_W-1:0] w_round_out;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // Forward step rk(n-1) -> rk(n) and backward step rk(n) -> rk(n-1), both keyed by r_rcnt.
    always_comb begin
        w_f0 = w_w0 ^ sub_rot_word(w_w3) ^ {rcon(r_rcnt), 24'h0};
        w_f1 = w_w1 ^ w_f0;
        w_f2 = w_w2 ^ w_f1;
        w_f3 = w_w3 ^ w_f2;
        w_p3 = w_w3 ^ w_w2;
        w_p2 = w_w2 ^ w_w1;
        w_p1 = w_w1 ^ w_w0;
        w_p0 = w_w0 ^ sub_rot_word(w_p3) ^ {rcon(r_rcnt), 24'h0};
        w_key_fwd = {w_f0, w_f1, w_f2, w_f3};
        w_key_bwd = {w_p0, w_p1, w_p2, w_p3};
    end

    aes_inv_round_128 u_round (
        .state_in  (r_state),
        .round_key (w_key_bwd),
        .skip_mix  (r_rcnt == 4'd1),
        .state_out (w_round_out)
    );

    assign in_ready = (r_fsm == IDLE);
    assign busy     = (r_fsm == KEXP) || (r_fsm == ROUND);

    // Control FSM owning the key, state, round counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= IDLE;
            r_key      <= '0;
            r_state    <= '0;
            r_rcnt     <= 4'd0;
            out_valid  <= 1'b0;
            plain_text <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= cipher_text;
                        r_key   <= key;
                        r_rcnt  <= 4'd1;
                        r_fsm   <= KEXP;
                    end
                end
                KEXP: begin
                    r_key <= w_key_fwd;
                    if (r_rcnt == 4'(NUM_ROUNDS)) begin
                        r_state <= r_state ^ w_key_fwd;
                        r_fsm   <= ROUND;
                    end else begin
                        r_rcnt <= r_rcnt + 4'd1;
                    end
                end
                ROUND: begin
                    r_key   <= w_key_bwd;
                    r_state <= w_round_out;
                    r_rcnt  <= r_rcnt - 4'd1;
                    if (r_rcnt == 4'd1) begin
                        plain_text <= w_round_out;
                        out_valid  <= 1'b1;
                        r_fsm      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_fsm     <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_128_iter.sv
// Directed-vector bench for the iterative AES-128 decryptor.
module tb_decryption_128_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] cipher_text = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] plain_text;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R2  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C4  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P4  = 128'h6bc1bee22e409f96e93d7e117393172a;

    decryption_128_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cipher_text (cipher_text),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plain_text  (plain_text),
        .busy        (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    // Wait (bounded) for out_valid after the acceptance edge, optionally probing rk10.
    task automatic waitDone(input string tag, input logic chkRk, input logic [127:0] expRk);
        int n;
        n = 0;
        while (n < 100 && !out_valid) begin
            tick();
            n++;
            if (n == 10 && chkRk) checkOutput({tag, " rk10"}, dut.r_key, expRk);
        end
        checkOutput({tag, " latency"}, 128'(n), 128'd20);
    endtask

    // Full transaction: accept, wait for result, optionally stall, then hand off.
    task automatic applyStimulus(input string tag, input logic [127:0] ct, input logic [127:0] k,
                                 input logic [127:0] expPt, input logic chkRk,
                                 input logic [127:0] expRk, input int stall);
        checkOutput({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
        cipher_text = ct;
        key         = k;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput({tag, " busy"}, 128'(busy), 128'd1);
        waitDone(tag, chkRk, expRk);
        checkOutput({tag, " plain_text"}, plain_text, expPt);
        checkOutput({tag, " busy done"}, 128'(busy), 128'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput({tag, " stall out_valid"}, 128'(out_valid), 128'd1);
            checkOutput({tag, " stall plain_text"}, plain_text, expPt);
            checkOutput({tag, " stall in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, " out_valid drop"}, 128'(out_valid), 128'd0);
        checkOutput({tag, " in_ready back"}, 128'(in_ready), 128'd1);
        checkOutput({tag, " plain_text kept"}, plain_text, expPt);
    endtask

    // Start vector 1, assert rst so it lands on edge E<edgeNum>, verify abort.
    task automatic abortAt(input string tag, input int edgeNum);
        logic sawValid;
        cipher_text = C1;
        key         = K1;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (edgeNum - 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput({tag, " in_ready"}, 128'(in_ready), 128'd1);
        checkOutput({tag, " out_valid"}, 128'(out_valid), 128'd0);
        checkOutput({tag, " plain_text"}, plain_text, 128'd0);
        checkOutput({tag, " busy"}, 128'(busy), 128'd0);
        sawValid = 1'b0;
        repeat (25) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput({tag, " no pulse"}, 128'(sawValid), 128'd0);
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        checkOutput("reset in_ready", 128'(in_ready), 128'd1);
        checkOutput("reset out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset busy", 128'(busy), 128'd0);
        checkOutput("reset plain_text", plain_text, 128'd0);

        applyStimulus("fips_b", C1, K1, P1, 1'b1, R1, 0);
        applyStimulus("fips_c1", C2, K2, P2, 1'b1, R2, 0);
        applyStimulus("zero_key", C3, 128'd0, 128'd0, 1'b0, 128'd0, 15);
        applyStimulus("sp800_38a", C4, K1, P4, 1'b1, R1, 0);

        // Back-to-back: in_valid stays high; the second vector waits for the first hand-off.
        cipher_text = C1;
        key         = K1;
        in_valid    = 1'b1;
        tick();
        cipher_text = C2;
        key         = K2;
        waitDone("b2b first", 1'b0, 128'd0);
        checkOutput("b2b first plain_text", plain_text, P1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b in_ready after hand-off", 128'(in_ready), 128'd1);
        checkOutput("b2b out_valid after hand-off", 128'(out_valid), 128'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("b2b second accepted", 128'(busy), 128'd1);
        waitDone("b2b second", 1'b0, 128'd0);
        checkOutput("b2b second plain_text", plain_text, P2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        abortAt("rst_kexp", 7);
        abortAt("rst_round", 15);

        // Reset and in_valid together: nothing may be captured.
        cipher_text = C1;
        key         = K1;
        in_valid    = 1'b1;
        rst         = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst+in_valid busy", 128'(busy), 128'd0);
        checkOutput("rst+in_valid in_ready", 128'(in_ready), 128'd1);

        applyStimulus("after_rst", C1, K1, P1, 1'b1, R1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
